// File: rtl/spectral_peak_tracker_pkg.sv
// -----------------------------------------------------------------------------
// spt_pkg
// Shared types and width helpers for the spectral peak tracker.
//   spt_state_e  : tracker FSM states (ACCUM, SCAN, HOLD)
//   clog2_min1() : $clog2 that never returns 0, so counters stay at least 1 bit
//   bin_w()      : width of a bin index for a given NBINS
//   beat_w()     : width of the beat/scan counters for NBINS/LANES beats
//   frm_w()      : width of the frame counter for ACC_FRAMES frames
// -----------------------------------------------------------------------------
package spt_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    HOLD  = 2'd2
  } spt_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int bin_w(input int nbins);
    return clog2_min1(nbins);
  endfunction

  function automatic int beat_w(input int nbins, input int lanes);
    return clog2_min1(nbins / lanes);
  endfunction

  function automatic int frm_w(input int acc_frames);
    return clog2_min1(acc_frames);
  endfunction

endpackage

// File: rtl/spectral_peak_tracker_cmp_tree.sv
// -----------------------------------------------------------------------------
// peak_cmp_tree
// Combinational LANES-input argmax. Lanes are paired up in a binary tree of
// 2-input max/tag muxes; at every node the higher-index side only wins when it
// is strictly larger, so ties resolve to the lowest lane index.
// Ports:
//   mags      in   LANES*MAG_W  lane l magnitude at bits l*MAG_W+:MAG_W
//   best_mag  out  MAG_W        largest magnitude
//   best_lane out  LANE_W       lane that holds it (lowest index on ties)
// -----------------------------------------------------------------------------
module peak_cmp_tree
  import spt_pkg::*;
#(
  parameter int MAG_W  = 34,
  parameter int LANES  = 4,
  localparam int LANE_W = clog2_min1(LANES)
) (
  input  logic [LANES*MAG_W-1:0] mags,
  output logic [MAG_W-1:0]       best_mag,
  output logic [LANE_W-1:0]      best_lane
);

  // Tree padded to a power of two; padding leaves carry magnitude 0 and can
  // never win against a real lane because replacement needs strict '>'.
  localparam int LP = 1 << $clog2(LANES);

  // Heap layout: root at 0, children of n at 2n+1 (lower lanes) and 2n+2.
  logic [MAG_W-1:0]  node_mag [2*LP-1];
  logic [LANE_W-1:0] node_tag [2*LP-1];

  genvar gi;
  generate
    for (gi = 0; gi < LP; gi++) begin : g_leaf
      if (gi < LANES) begin : g_real
        assign node_mag[LP-1+gi] = mags[gi*MAG_W +: MAG_W];
      end else begin : g_pad
        assign node_mag[LP-1+gi] = '0;
      end
      assign node_tag[LP-1+gi] = LANE_W'(gi);
    end

    for (gi = 0; gi < LP-1; gi++) begin : g_node
      logic right_wins;
      assign right_wins    = node_mag[2*gi+2] > node_mag[2*gi+1];
      assign node_mag[gi]  = right_wins ? node_mag[2*gi+2] : node_mag[2*gi+1];
      assign node_tag[gi]  = right_wins ? node_tag[2*gi+2] : node_tag[2*gi+1];
    end
  endgenerate

  assign best_mag  = node_mag[0];
  assign best_lane = node_tag[0];

endmodule

// File: rtl/spectral_peak_tracker.sv
// -----------------------------------------------------------------------------
// spectral_peak_tracker
// Streaming FFT-magnitude peak detector. Bins arrive LANES per beat, are summed
// per bin over ACC_FRAMES frames, then the sums are scanned LANES per cycle for
// the argmax bin (lowest index wins ties). The result is held until accepted.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       synchronous abort of partial sums and any pending result
//   in_valid/in_ready/in_data/in_last   beat input (lane l = bin beat*LANES+l)
//   out_valid/out_ready/out_bin/out_mag result output, held until handshake
//   frame_err   one-cycle pulse when in_last does not match the beat position
// -----------------------------------------------------------------------------
module spectral_peak_tracker
  import spt_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NBINS      = 16,
  parameter int LANES      = 4,
  parameter int ACC_FRAMES = 4,
  localparam int ACC_W     = DATA_W + $clog2(ACC_FRAMES) + 1,
  localparam int BIN_W     = bin_w(NBINS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIN_W-1:0]        out_bin,
  output logic [ACC_W-1:0]        out_mag,
  output logic                    frame_err
);

  localparam int BEATS  = NBINS / LANES;
  localparam int BEAT_W = beat_w(NBINS, LANES);
  localparam int FRM_W  = frm_w(ACC_FRAMES);
  localparam int LANE_W = clog2_min1(LANES);

  spt_state_e        state_reg, state_next;
  logic [BEAT_W-1:0] beat_cnt_reg;
  logic [BEAT_W-1:0] scan_idx_reg;
  logic [FRM_W-1:0]  frame_cnt_reg;
  logic              commit_reg;
  logic [ACC_W-1:0]  best_mag_reg;
  logic [BIN_W-1:0]  best_bin_reg;
  logic              out_valid_reg;
  logic [BIN_W-1:0]  out_bin_reg;
  logic [ACC_W-1:0]  out_mag_reg;
  logic              frame_err_reg;

  logic [ACC_W-1:0]  acc_reg [NBINS];

  // ---------------------------------------------------------------------------
  // Input beat qualification
  // ---------------------------------------------------------------------------
  logic beat_fire, last_beat, frm_mismatch, acc_we, run_done;

  assign in_ready     = (state_reg == ACCUM);
  assign beat_fire    = in_valid && in_ready && !clear;
  assign last_beat    = (beat_cnt_reg == BEAT_W'(BEATS-1));
  assign frm_mismatch = beat_fire && (in_last != last_beat);
  assign acc_we       = beat_fire && !frm_mismatch;
  assign run_done     = acc_we && last_beat && (frame_cnt_reg == FRM_W'(ACC_FRAMES-1));

  logic [DATA_W-1:0] lane_data [LANES];
  logic [BIN_W-1:0]  wr_base;
  logic [BIN_W-1:0]  scan_base;
  logic [LANES*ACC_W-1:0] scan_mags;

  assign wr_base   = BIN_W'(int'(beat_cnt_reg) * LANES);
  assign scan_base = BIN_W'(int'(scan_idx_reg) * LANES);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_data[gi]                  = in_data[gi*DATA_W +: DATA_W];
      assign scan_mags[gi*ACC_W +: ACC_W]   = acc_reg[scan_base + BIN_W'(gi)];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Scan comparator
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0]  cmp_mag;
  logic [LANE_W-1:0] cmp_lane;
  logic [BIN_W-1:0]  cand_bin;
  logic              take_cand;

  peak_cmp_tree #(
    .MAG_W (ACC_W),
    .LANES (LANES)
  ) u_cmp_tree (
    .mags      (scan_mags),
    .best_mag  (cmp_mag),
    .best_lane (cmp_lane)
  );

  assign cand_bin  = scan_base + BIN_W'(cmp_lane);
  // First scan beat seeds the running best; later beats need a strict win so
  // an earlier (lower) bin keeps a tie.
  assign take_cand = (scan_idx_reg == '0) || (cmp_mag > best_mag_reg);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ACCUM;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = ACCUM;
    end else begin
      case (state_reg)
        ACCUM:   if (run_done)   state_next = SCAN;
        SCAN:    if (commit_reg) state_next = HOLD;
        HOLD:    if (out_ready)  state_next = ACCUM;
        default:                 state_next = ACCUM;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator array: frame 0 loads, later frames add. Errored beats and
  // dropped (clear) beats never write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (acc_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (frame_cnt_reg == '0)
          acc_reg[wr_base + BIN_W'(l)] <= ACC_W'(lane_data[l]);
        else
          acc_reg[wr_base + BIN_W'(l)] <= acc_reg[wr_base + BIN_W'(l)] + ACC_W'(lane_data[l]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, running best and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
      scan_idx_reg  <= '0;
      commit_reg    <= 1'b0;
      best_mag_reg  <= '0;
      best_bin_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_bin_reg   <= '0;
      out_mag_reg   <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= frm_mismatch;
      if (clear) begin
        beat_cnt_reg  <= '0;
        frame_cnt_reg <= '0;
        scan_idx_reg  <= '0;
        commit_reg    <= 1'b0;
        out_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          ACCUM: begin
            if (frm_mismatch) begin
              beat_cnt_reg  <= '0;
              frame_cnt_reg <= '0;
            end else if (acc_we) begin
              if (last_beat) begin
                beat_cnt_reg <= '0;
                if (run_done) begin
                  frame_cnt_reg <= '0;
                  scan_idx_reg  <= '0;
                  commit_reg    <= 1'b0;
                end else begin
                  frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
              end else begin
                beat_cnt_reg <= beat_cnt_reg + 1'b1;
              end
            end
          end
          SCAN: begin
            // BEATS compare cycles, then one cycle to register the result.
            if (!commit_reg) begin
              if (take_cand) begin
                best_mag_reg <= cmp_mag;
                best_bin_reg <= cand_bin;
              end
              if (scan_idx_reg == BEAT_W'(BEATS-1)) commit_reg   <= 1'b1;
              else                                   scan_idx_reg <= scan_idx_reg + 1'b1;
            end else begin
              out_bin_reg   <= best_bin_reg;
              out_mag_reg   <= best_mag_reg;
              out_valid_reg <= 1'b1;
              commit_reg    <= 1'b0;
            end
          end
          HOLD: begin
            if (out_ready) out_valid_reg <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_bin   = out_bin_reg;
  assign out_mag   = out_mag_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spectral_peak_tracker.sv
// -----------------------------------------------------------------------------
// tb_spectral_peak_tracker
// Scoreboard bench: each completed run of frames pushes the expected {bin,mag}
// computed by a reference argmax model; results are popped and compared when
// the DUT raises out_valid.
// -----------------------------------------------------------------------------
module tb_spectral_peak_tracker;

  localparam int DATA_W     = 32;
  localparam int NBINS      = 16;
  localparam int LANES      = 4;
  localparam int ACC_FRAMES = 2;
  localparam int ACC_W      = 34;
  localparam int BIN_W      = 4;
  localparam int BEATS      = NBINS / LANES;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    clear = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_last = 1'b0;
  logic                    out_ready = 1'b0;
  logic [LANES*DATA_W-1:0] in_data = '0;
  logic                    in_ready;
  logic                    out_valid;
  logic [BIN_W-1:0]        out_bin;
  logic [ACC_W-1:0]        out_mag;
  logic                    frame_err;

  spectral_peak_tracker #(
    .DATA_W     (DATA_W),
    .NBINS      (NBINS),
    .LANES      (LANES),
    .ACC_FRAMES (ACC_FRAMES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_mag   (out_mag),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic [ACC_W-1:0] mag;
  } exp_t;

  exp_t             exp_q[$];
  logic [DATA_W-1:0] fd   [NBINS];
  logic [ACC_W-1:0]  macc [NBINS];
  int model_frames = 0;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int err_pulses = 0;
  int txn = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready && in_last) last_cyc <= cyc + 1;
  end

  always @(negedge clk) if (frame_err) err_pulses = err_pulses + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [DATA_W-1:0] v);
    for (int i = 0; i < NBINS; i++) fd[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NBINS; i++) fd[i] = DATA_W'($urandom_range(0, 1000));
  endtask

  // Drives one frame from fd. bad_beat >= 0 ends the frame early with in_last
  // on that beat (a framing error).
  task automatic send_frame(input int bad_beat);
    int nb;
    int best;
    nb = (bad_beat >= 0) ? bad_beat + 1 : BEATS;
    for (int b = 0; b < nb; b++) begin
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) check("in_ready_timeout", in_ready, 1);
      in_valid = 1'b1;
      in_last  = (b == nb - 1);
      for (int l = 0; l < LANES; l++) in_data[l*DATA_W +: DATA_W] = fd[b*LANES + l];
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (bad_beat >= 0) begin
      model_frames = 0;
    end else begin
      for (int i = 0; i < NBINS; i++)
        macc[i] = (model_frames == 0) ? ACC_W'(fd[i]) : macc[i] + ACC_W'(fd[i]);
      model_frames++;
      if (model_frames == ACC_FRAMES) begin
        best = 0;
        for (int i = 1; i < NBINS; i++) if (macc[i] > macc[best]) best = i;
        exp_q.push_back('{bin: BIN_W'(best), mag: macc[best]});
        model_frames = 0;
      end
    end
  endtask

  task automatic send_run();
    for (int f = 0; f < ACC_FRAMES; f++) send_frame(-1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_rise", out_valid, 1);
  endtask

  task automatic collect(input int hold, input bit chk_lat);
    exp_t e;
    wait_valid();
    if (exp_q.size() == 0) begin
      check("scoreboard_size", exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    if (chk_lat) check("latency", cyc - last_cyc, 5);
    check("in_ready_in_hold", in_ready, 0);
    check("out_bin", out_bin, e.bin);
    check("out_mag", out_mag, e.mag);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_bin", out_bin, e.bin);
      check("hold_mag", out_mag, e.mag);
      check("hold_in_ready", in_ready, 0);
    end
    txn++;
    $display("txn %0d: bin=%0d mag=0x%0h expected bin=%0d mag=0x%0h",
             txn, out_bin, out_mag, e.bin, e.mag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_ack_valid", out_valid, 0);
    check("post_ack_in_ready", in_ready, 1);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bin", out_bin, 0);
    check("rst_out_mag", out_mag, 0);
    check("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // 1. Single dominant bin
    fill(1); fd[9] = 100;
    send_run();
    collect(0, 1);

    // 2. Cross-beat tie (3 vs 12) and same-beat tie (4 vs 5)
    fill(0); fd[3] = 50; fd[12] = 50;
    send_run();
    collect(0, 1);
    fill(0); fd[4] = 50; fd[5] = 50;
    send_run();
    collect(0, 1);

    // 3. Backpressure on the result, random data
    fill_rand(); send_frame(-1);
    fill_rand(); send_frame(-1);
    collect(10, 1);

    // 4. Framing error then two good frames
    fill(500);
    send_frame(2);
    @(negedge clk);
    check("frame_err_pulses", err_pulses, 1);
    fill(0); fd[7] = 9;
    send_run();
    collect(0, 1);
    check("frame_err_pulses_after", err_pulses, 1);

    // 5. Full-scale accumulation
    fill(32'hFFFF_FFFF);
    send_run();
    collect(0, 1);

    // 6a. Reset during SCAN
    fill_rand();
    send_run();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_scan_out_valid", out_valid, 0);
    check("rst_scan_out_mag", out_mag, 0);
    check("rst_scan_in_ready", in_ready, 1);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    model_frames = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", in_ready, 1);
    fill(2); fd[14] = 3;
    send_run();
    collect(0, 1);

    // 6b. clear while holding a result
    fill(5); fd[1] = 6;
    send_run();
    wait_valid();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_out_valid", out_valid, 0);
    check("clear_in_ready", in_ready, 1);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    fill(0); fd[15] = 1;
    send_run();
    collect(0, 1);
    check("frame_err_pulses_final", err_pulses, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
